// File: rtl/gpr_bank_if.sv
// Bus bundle for gpr_bank: read ports, write port, overflow flag controls and the debug dump stream.
// The master side drives addresses, write data and dump handshakes; the slave side is the register bank.
interface gpr_bank_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
);
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*WIDTH-1:0] rdata;
  logic                 we;
  logic [AW-1:0]        waddr;
  logic [WIDTH-1:0]     wdata;
  logic                 ovf_set;
  logic                 ovf_clr;
  logic                 dbg_start;
  logic                 dbg_ready;
  logic                 dbg_valid;
  logic [AW-1:0]        dbg_idx;
  logic [WIDTH-1:0]     dbg_data;
  logic                 dbg_busy;
  logic                 dbg_done;

  modport master (
    output raddr, we, waddr, wdata, ovf_set, ovf_clr, dbg_start, dbg_ready,
    input  rdata, dbg_valid, dbg_idx, dbg_data, dbg_busy, dbg_done
  );

  modport slave (
    input  raddr, we, waddr, wdata, ovf_set, ovf_clr, dbg_start, dbg_ready,
    output rdata, dbg_valid, dbg_idx, dbg_data, dbg_busy, dbg_done
  );
endinterface

// File: rtl/gpr_bank.sv
// MIPS general-purpose register bank: NRD combinational read ports, one write port, sticky
// overflow flag in FLAG_IDX bit 0, and a valid/ready engine that dumps every register in order.
module gpr_bank #(
  parameter int               WIDTH    = 32,
  parameter int               AW       = 5,
  parameter int               NRD      = 2,
  parameter int               BYPASS   = 1,
  parameter int               GP_IDX   = 28,
  parameter logic [WIDTH-1:0] GP_INIT  = WIDTH'(32'h0000_1800),
  parameter int               SP_IDX   = 29,
  parameter logic [WIDTH-1:0] SP_INIT  = WIDTH'(32'h0000_2ffc),
  parameter int               FLAG_IDX = 30
) (
  input  logic        clk,
  input  logic        rst,
  gpr_bank_if.slave   gpr_if
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  logic [WIDTH-1:0]     regs_q [DEPTH];
  logic [WIDTH-1:0]     regs_d [DEPTH];
  logic [NRD*WIDTH-1:0] rdata_w;

  state_e               state_q;
  logic [AW-1:0]        dbg_idx_q;
  logic                 dbg_valid_q;
  logic                 dbg_busy_q;
  logic                 dbg_done_q;

  function automatic logic [WIDTH-1:0] reset_value(input int idx);
    if (idx == GP_IDX) return GP_INIT;
    if (idx == SP_IDX) return SP_INIT;
    return '0;
  endfunction

  // Next value per register: write first, then the flag bit overrides in set > clr > hold order.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_next
      if (gi == 0) begin : g_zero
        assign regs_d[gi] = '0;
      end else begin : g_wr
        logic [WIDTH-1:0] wv;
        assign wv = (gpr_if.we && gpr_if.waddr == AW'(gi)) ? gpr_if.wdata : regs_q[gi];
        if (gi == FLAG_IDX) begin : g_flag
          assign regs_d[gi] = {wv[WIDTH-1:1], gpr_if.ovf_set | (~gpr_if.ovf_clr & wv[0])};
        end else begin : g_plain
          assign regs_d[gi] = wv;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= reset_value(i);
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Bypass forwards wdata for the register being written; address 0 always reads as zero.
  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]    ra;
      logic [WIDTH-1:0] byp;
      assign ra  = gpr_if.raddr[gi*AW +: AW];
      assign byp = {gpr_if.wdata[WIDTH-1:1],
                    gpr_if.wdata[0] | (gpr_if.ovf_set && ra == AW'(FLAG_IDX))};
      assign rdata_w[gi*WIDTH +: WIDTH] =
          (ra == '0) ? '0 :
          ((BYPASS != 0) && gpr_if.we && gpr_if.waddr == ra) ? byp : regs_q[ra];
    end
  endgenerate

  assign gpr_if.rdata = rdata_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dbg_idx_q   <= '0;
      dbg_valid_q <= 1'b0;
      dbg_busy_q  <= 1'b0;
      dbg_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          dbg_done_q <= 1'b0;
          if (gpr_if.dbg_start) begin
            state_q     <= SEND;
            dbg_idx_q   <= '0;
            dbg_valid_q <= 1'b1;
            dbg_busy_q  <= 1'b1;
          end
        end
        SEND: begin
          if (gpr_if.dbg_ready) begin
            if (dbg_idx_q == AW'(DEPTH - 1)) begin
              state_q     <= DONE;
              dbg_valid_q <= 1'b0;
              dbg_done_q  <= 1'b1;
            end else begin
              dbg_idx_q <= dbg_idx_q + AW'(1);
            end
          end
        end
        DONE: begin
          state_q     <= IDLE;
          dbg_done_q  <= 1'b0;
          dbg_busy_q  <= 1'b0;
          dbg_idx_q   <= '0;
        end
        default: begin
          state_q     <= IDLE;
          dbg_idx_q   <= '0;
          dbg_valid_q <= 1'b0;
          dbg_busy_q  <= 1'b0;
          dbg_done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Dump data is the live stored value, so a write to the word on offer shows up while stalled.
  assign gpr_if.dbg_data  = regs_q[dbg_idx_q];
  assign gpr_if.dbg_idx   = dbg_idx_q;
  assign gpr_if.dbg_valid = dbg_valid_q;
  assign gpr_if.dbg_busy  = dbg_busy_q;
  assign gpr_if.dbg_done  = dbg_done_q;

endmodule

// File: tb/tb_gpr_bank.sv
// Directed bench for gpr_bank: a bypassing and a non-bypassing instance share identical stimulus.
module tb_gpr_bank;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_reg [32];
  int   eidx;

  gpr_bank_if #(.WIDTH(32), .AW(5), .NRD(2)) b ();
  gpr_bank_if #(.WIDTH(32), .AW(5), .NRD(2)) nb ();

  gpr_bank #(.BYPASS(1)) dut    (.clk(clk), .rst(rst), .gpr_if(b));
  gpr_bank #(.BYPASS(0)) dut_nb (.clk(clk), .rst(rst), .gpr_if(nb));

  assign nb.raddr     = b.raddr;
  assign nb.we        = b.we;
  assign nb.waddr     = b.waddr;
  assign nb.wdata     = b.wdata;
  assign nb.ovf_set   = b.ovf_set;
  assign nb.ovf_clr   = b.ovf_clr;
  assign nb.dbg_start = b.dbg_start;
  assign nb.dbg_ready = b.dbg_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  initial begin
    rst         = 1'b1;
    b.raddr     = '0;
    b.we        = 1'b0;
    b.waddr     = '0;
    b.wdata     = '0;
    b.ovf_set   = 1'b0;
    b.ovf_clr   = 1'b0;
    b.dbg_start = 1'b0;
    b.dbg_ready = 1'b0;
    for (int i = 0; i < 32; i++) exp_reg[i] = 32'h0;
    exp_reg[28] = 32'h0000_1800;
    exp_reg[29] = 32'h0000_2ffc;

    #1;
    chk("rst_valid", {31'b0, b.dbg_valid}, 32'h0);
    chk("rst_busy",  {31'b0, b.dbg_busy},  32'h0);
    chk("rst_done",  {31'b0, b.dbg_done},  32'h0);
    chk("rst_idx",   {27'b0, b.dbg_idx},   32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset contents
    b.raddr = {5'd28, 5'd0};
    #1;
    chk("rd_r0",  b.rdata[31:0],  32'h0);
    chk("rd_r28", b.rdata[63:32], 32'h0000_1800);
    b.raddr = {5'd5, 5'd29};
    #1;
    chk("rd_r29", b.rdata[31:0],  32'h0000_2ffc);
    chk("rd_r5",  b.rdata[63:32], 32'h0);

    // Write to r0 is dropped, including the bypass path
    @(negedge clk);
    b.we = 1'b1; b.waddr = 5'd0; b.wdata = 32'hdead_beef; b.raddr = {5'd0, 5'd0};
    #1;
    chk("r0_bypass", b.rdata[31:0], 32'h0);
    @(negedge clk);
    b.we = 1'b0;
    #1;
    chk("r0_after",    b.rdata[31:0],  32'h0);
    chk("r0_after_nb", nb.rdata[31:0], 32'h0);

    // Bypass vs. no bypass
    @(negedge clk);
    b.we = 1'b1; b.waddr = 5'd7; b.wdata = 32'h1234_5678; b.raddr = {5'd0, 5'd7};
    #1;
    chk("byp_on",  b.rdata[31:0],  32'h1234_5678);
    chk("byp_off", nb.rdata[31:0], 32'h0);
    @(negedge clk);
    b.we = 1'b0;
    #1;
    chk("wr7",    b.rdata[31:0],  32'h1234_5678);
    chk("wr7_nb", nb.rdata[31:0], 32'h1234_5678);
    exp_reg[7] = 32'h1234_5678;

    // Sticky overflow flag
    @(negedge clk);
    b.we = 1'b1; b.waddr = 5'd30; b.wdata = 32'h0000_00f0; b.ovf_set = 1'b1;
    b.raddr = {5'd30, 5'd30};
    #1;
    chk("flag_byp",    b.rdata[31:0],  32'h0000_00f1);
    chk("flag_byp_nb", nb.rdata[31:0], 32'h0);
    @(negedge clk);
    b.we = 1'b0; b.ovf_set = 1'b0;
    #1;
    chk("flag_set_wr", b.rdata[31:0],   32'h0000_00f1);
    chk("flag_set_nb", nb.rdata[63:32], 32'h0000_00f1);
    b.ovf_clr = 1'b1;
    @(negedge clk);
    b.ovf_clr = 1'b0;
    #1;
    chk("flag_clr", b.rdata[31:0], 32'h0000_00f0);
    b.ovf_set = 1'b1; b.ovf_clr = 1'b1;
    @(negedge clk);
    b.ovf_set = 1'b0; b.ovf_clr = 1'b0;
    #1;
    chk("flag_set_clr", b.rdata[31:0], 32'h0000_00f1);
    b.we = 1'b1; b.waddr = 5'd30; b.wdata = 32'h0000_0ff3; b.ovf_clr = 1'b1;
    @(negedge clk);
    b.we = 1'b0; b.ovf_clr = 1'b0;
    #1;
    chk("flag_clr_wr", b.rdata[31:0], 32'h0000_0ff2);
    b.ovf_set = 1'b1;
    @(negedge clk);
    b.ovf_set = 1'b0;
    #1;
    chk("flag_set_hold", b.rdata[31:0], 32'h0000_0ff3);
    exp_reg[30] = 32'h0000_0ff3;

    // Dump with ready tied high
    b.dbg_ready = 1'b1; b.dbg_start = 1'b1;
    @(negedge clk);
    b.dbg_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk($sformatf("d1_valid_%0d", i), {31'b0, b.dbg_valid}, 32'h1);
      chk($sformatf("d1_idx_%0d", i),   {27'b0, b.dbg_idx},   i);
      chk($sformatf("d1_data_%0d", i),  b.dbg_data,           exp_reg[i]);
      chk($sformatf("d1_done_%0d", i),  {31'b0, b.dbg_done},  32'h0);
      @(negedge clk);
    end
    #1;
    chk("d1_done",       {31'b0, b.dbg_done},  32'h1);
    chk("d1_done_valid", {31'b0, b.dbg_valid}, 32'h0);
    chk("d1_done_busy",  {31'b0, b.dbg_busy},  32'h1);
    @(negedge clk);
    #1;
    chk("d1_idle_busy", {31'b0, b.dbg_busy}, 32'h0);
    chk("d1_idle_done", {31'b0, b.dbg_done}, 32'h0);
    chk("d1_idle_idx",  {27'b0, b.dbg_idx},  32'h0);

    // Dump with ready pattern 1,0,0,..., a mid-dump start pulse and a write to a stalled word
    @(negedge clk);
    b.dbg_start = 1'b1;
    @(negedge clk);
    b.dbg_start = 1'b0;
    eidx = 0;
    for (int cyc = 0; cyc < 200 && eidx < 32; cyc++) begin
      b.dbg_ready = (cyc % 3 == 0);
      b.dbg_start = (cyc == 7);
      b.we        = (cyc == 16);
      b.waddr     = eidx[4:0];
      b.wdata     = 32'hcafe_0000 + eidx;
      #1;
      chk($sformatf("d2_valid_c%0d", cyc), {31'b0, b.dbg_valid}, 32'h1);
      chk($sformatf("d2_idx_c%0d", cyc),   {27'b0, b.dbg_idx},   eidx);
      chk($sformatf("d2_data_c%0d", cyc),  b.dbg_data,           exp_reg[eidx]);
      chk($sformatf("d2_done_c%0d", cyc),  {31'b0, b.dbg_done},  32'h0);
      @(posedge clk);
      if (b.we) exp_reg[b.waddr] = b.wdata;
      if (b.dbg_ready) eidx++;
      @(negedge clk);
    end
    b.we = 1'b0; b.dbg_start = 1'b0; b.dbg_ready = 1'b1;
    chk("d2_words", eidx, 32);
    #1;
    chk("d2_done",       {31'b0, b.dbg_done},  32'h1);
    chk("d2_done_valid", {31'b0, b.dbg_valid}, 32'h0);
    @(negedge clk);

    // Reset in the middle of a dump
    @(negedge clk);
    b.dbg_start = 1'b1;
    @(negedge clk);
    b.dbg_start = 1'b0;
    b.raddr = {5'd7, 5'd28};
    repeat (10) @(negedge clk);
    #1;
    chk("d3_idx10",   {27'b0, b.dbg_idx},   32'd10);
    chk("d3_valid10", {31'b0, b.dbg_valid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("d3_rst_valid", {31'b0, b.dbg_valid}, 32'h0);
    chk("d3_rst_busy",  {31'b0, b.dbg_busy},  32'h0);
    chk("d3_rst_done",  {31'b0, b.dbg_done},  32'h0);
    chk("d3_rst_idx",   {27'b0, b.dbg_idx},   32'h0);
    chk("d3_rst_r28",   b.rdata[31:0],        32'h0000_1800);
    chk("d3_rst_r7",    b.rdata[63:32],       32'h0);
    @(negedge clk);
    rst = 1'b0;
    b.raddr = {5'd30, 5'd6};
    #1;
    chk("d3_rst_r6",  b.rdata[31:0],  32'h0);
    chk("d3_rst_r30", b.rdata[63:32], 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("d3_post_done_%0d", i), {31'b0, b.dbg_done}, 32'h0);
      chk($sformatf("d3_post_busy_%0d", i), {31'b0, b.dbg_busy}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
